// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing a single register-file access port between the
// core (requester 0) and a debug/loader agent (requester 1) that can lock the core out.
module regfile_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  input  logic              r1_lock,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  logic              prio_q, prio_d;
  logic              r0_rvalid_q, r0_rvalid_d;
  logic              r1_rvalid_q, r1_rvalid_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

  logic e0, e1, grant0, grant1;

  // Grants are gated by reset so nothing transfers while the block is held in reset.
  always_comb begin
    e0     = r0_valid & ~r1_lock;
    e1     = r1_valid;
    grant0 = reset & e0 & (~e1 | ~prio_q);
    grant1 = reset & e1 & (~e0 | prio_q);
  end

  always_comb begin
    rf_addr  = grant1 ? r1_addr  : r0_addr;
    rf_wdata = grant1 ? r1_wdata : r0_wdata;
    rf_we    = (grant0 & r0_we & (|r0_addr)) | (grant1 & r1_we & (|r1_addr));
  end

  always_comb begin
    prio_d      = prio_q;
    r0_rvalid_d = grant0 & ~r0_we;
    r1_rvalid_d = grant1 & ~r1_we;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
    if (grant0) prio_d = 1'b1;
    if (grant1) prio_d = 1'b0;
    if (r0_rvalid_d) r0_rdata_d = rf_rdata;
    if (r1_rvalid_d) r1_rdata_d = rf_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q      <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      prio_q      <= prio_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign r0_ready  = grant0;
  assign r1_ready  = grant1;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed plus randomized bench for regfile_port_arbiter, checked against a
// transaction-level model of the register file and the arbitration rules.
module tb_regfile_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_valid, r0_we, r0_ready, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_we, r1_ready, r1_rvalid, r1_lock;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [AW-1:0] rf_addr;
  logic          rf_we;
  logic [DW-1:0] rf_wdata, rf_rdata;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  logic [DW-1:0] tb_rf [32];

  bit            m_prio;
  logic          m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;
  logic [DW-1:0] m_mem [32];
  int            last_win;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .r1_lock(r1_lock),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  // Register file the arbiter drives; x0 always reads zero.
  always @(posedge clk) if (rf_we) tb_rf[rf_addr] <= rf_wdata;
  assign rf_rdata = (rf_addr == '0) ? '0 : tb_rf[rf_addr];

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs: check grant outputs,
  // advance the model across the edge, then check the response registers.
  task automatic apply_stimulus();
    bit            e0, e1, exp_we;
    int            win;
    logic [AW-1:0] exp_addr;
    #1;
    e0  = reset && r0_valid && !r1_lock;
    e1  = reset && r1_valid;
    win = -1;
    if (e0 && e1) win = m_prio ? 1 : 0;
    else if (e0)  win = 0;
    else if (e1)  win = 1;
    exp_addr = (win == 1) ? r1_addr : r0_addr;
    exp_we   = (win == 0 && r0_we && r0_addr != 0) || (win == 1 && r1_we && r1_addr != 0);
    check_output("r0_ready", 32'(r0_ready), 32'(win == 0));
    check_output("r1_ready", 32'(r1_ready), 32'(win == 1));
    check_output("rf_we", 32'(rf_we), 32'(exp_we));
    check_output("rf_addr", 32'(rf_addr), 32'(exp_addr));
    last_win = win;
    @(posedge clk);
    if (!reset) begin
      m_prio = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      m_rv0 = 1'b0;
      m_rv1 = 1'b0;
      if (win == 0) begin
        if (r0_we) begin
          if (r0_addr != 0) m_mem[r0_addr] = r0_wdata;
        end else begin
          m_rv0 = 1'b1; m_rd0 = m_mem[r0_addr];
        end
        m_prio = 1'b1;
      end else if (win == 1) begin
        if (r1_we) begin
          if (r1_addr != 0) m_mem[r1_addr] = r1_wdata;
        end else begin
          m_rv1 = 1'b1; m_rd1 = m_mem[r1_addr];
        end
        m_prio = 1'b0;
      end
    end
    #1;
    check_output("r0_rvalid", 32'(r0_rvalid), 32'(m_rv0));
    check_output("r1_rvalid", 32'(r1_rvalid), 32'(m_rv1));
    check_output("r0_rdata", r0_rdata, m_rd0);
    check_output("r1_rdata", r1_rdata, m_rd1);
  endtask

  initial begin
    bit pend0, pend1;
    for (int i = 0; i < 32; i++) begin
      tb_rf[i] = '0;
      m_mem[i] = '0;
    end
    m_prio = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;

    // Reset held with both requesters trying to write x5.
    reset = 1'b0; r1_lock = 1'b0;
    r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 5; r0_wdata = 32'h1111;
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 5; r1_wdata = 32'h2222;
    apply_stimulus();
    apply_stimulus();
    reset = 1'b1;
    apply_stimulus();

    // Core write then read of x5.
    r1_valid = 1'b0; r0_wdata = 3;
    apply_stimulus();
    r0_we = 1'b0;
    apply_stimulus();
    r0_valid = 1'b0;
    apply_stimulus();
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 5;
    apply_stimulus();

    // Round-robin with both valid for four cycles.
    r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 5; r0_wdata = 7;
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 9; r1_wdata = 11;
    repeat (4) apply_stimulus();
    r0_we = 1'b0; r1_we = 1'b0;
    apply_stimulus();
    r0_valid = 1'b0;
    apply_stimulus();
    r1_valid = 1'b0;
    apply_stimulus();

    // x0 write is accepted but suppressed.
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 0; r1_wdata = 32'hDEADBEEF;
    apply_stimulus();
    r1_we = 1'b0;
    apply_stimulus();
    r1_valid = 1'b0;
    apply_stimulus();

    // Lock out the core while the debug agent reads.
    r1_lock = 1'b1; r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 5;
    for (int i = 0; i < 5; i++) begin
      r1_valid = (i == 2); r1_we = 1'b0; r1_addr = 5;
      apply_stimulus();
    end
    r1_lock = 1'b0; r1_valid = 1'b0;
    apply_stimulus();
    r0_valid = 1'b0;
    apply_stimulus();

    // Reset sampled on the edge of a debug read.
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 9; reset = 1'b0;
    apply_stimulus();
    reset = 1'b1; r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 3; r0_wdata = 5;
    apply_stimulus();
    r0_valid = 1'b0;
    apply_stimulus();
    r1_valid = 1'b0;
    apply_stimulus();

    // Random traffic; each requester holds its request until granted.
    pend0 = 1'b0; pend1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pend0 && $urandom_range(0, 3) != 0) begin
        pend0 = 1'b1; r0_we = $urandom_range(0, 1) == 1;
        r0_addr = AW'($urandom_range(0, 7)); r0_wdata = $urandom;
      end
      if (!pend1 && $urandom_range(0, 3) != 0) begin
        pend1 = 1'b1; r1_we = $urandom_range(0, 1) == 1;
        r1_addr = AW'($urandom_range(0, 7)); r1_wdata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) r1_lock = ~r1_lock;
      r0_valid = pend0;
      r1_valid = pend1;
      apply_stimulus();
      if (last_win == 0) pend0 = 1'b0;
      if (last_win == 1) pend1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
